// File: rtl/traffic_sequencer_if.sv
// rtl/traffic_sequencer_if.sv - sensor inputs and lamp/debug outputs of the traffic sequencer
interface traffic_sequencer_if;
  logic       req2;
  logic       night;
  logic [5:0] led;
  logic       d;
  logic [2:0] phase;

  modport master (
    input  req2,
    input  night,
    output led,
    output d,
    output phase
  );

  modport slave (
    output req2,
    output night,
    input  led,
    input  d,
    input  phase
  );
endinterface

// File: rtl/traffic_sequencer.sv
// rtl/traffic_sequencer.sv - timed two-road six-phase traffic light sequencer
// Optional night flash mode is built in when TRAFFIC_NIGHT_FLASH_EN is defined.
module traffic_sequencer #(
  parameter int CLK_DIV  = 100000000,
  parameter int T_ALLRED = 1,
  parameter int T_GREEN1 = 10,
  parameter int T_GREEN2 = 6,
  parameter int T_YELLOW = 3
) (
  input logic clk,
  input logic rst_n,
  traffic_sequencer_if.master bus
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MAX_A = (T_ALLRED > T_GREEN1) ? T_ALLRED : T_GREEN1;
  localparam int MAX_B = (T_GREEN2 > T_YELLOW) ? T_GREEN2 : T_YELLOW;
  localparam int MAXD  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW    = (MAXD > 1) ? $clog2(MAXD) : 1;

  typedef enum logic [2:0] {
    S_RR1   = 3'd0,
    S_G1    = 3'd1,
    S_Y1    = 3'd2,
    S_RR2   = 3'd3,
    S_G2    = 3'd4,
    S_Y2    = 3'd5,
    S_NIGHT = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pcnt_q;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] dur_m1;
  logic          pending_q;
  logic          tick;
  logic          at_end;

  assign tick = (pcnt_q == PW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pcnt_q <= '0;
    else if (tick) pcnt_q <= '0;
    else           pcnt_q <= pcnt_q + 1'b1;
  end

  always_comb begin
    dur_m1 = TW'(T_ALLRED - 1);
    case (state_q)
      S_G1:         dur_m1 = TW'(T_GREEN1 - 1);
      S_G2:         dur_m1 = TW'(T_GREEN2 - 1);
      S_Y1, S_Y2:   dur_m1 = TW'(T_YELLOW - 1);
      default:      dur_m1 = TW'(T_ALLRED - 1);
    endcase
  end

  assign at_end = tick && (timer_q == dur_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RR1;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RR1:   if (at_end) state_d = S_G1;
      S_G1:    if (at_end && pending_q) state_d = S_Y1;
      S_Y1:    if (at_end) state_d = S_RR2;
      S_RR2:   if (at_end) state_d = S_G2;
      S_G2:    if (at_end) state_d = S_Y2;
      S_Y2:    if (at_end) state_d = S_RR1;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      S_NIGHT: if (tick && !bus.night) state_d = S_RR1;
`endif
      default: state_d = S_RR1;
    endcase
`ifdef TRAFFIC_NIGHT_FLASH_EN
    if (tick && bus.night && state_q != S_NIGHT) state_d = S_NIGHT;
`endif
  end

  // Timer saturates at duration-1, which is what lets G1 hold indefinitely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  timer_q <= '0;
    else if (state_d != state_q)                 timer_q <= '0;
    else if (tick && state_q != S_NIGHT && timer_q != dur_m1) timer_q <= timer_q + 1'b1;
  end

  // Clear on G2 entry takes priority over a coincident request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   pending_q <= 1'b0;
    else if (state_q == S_RR2 && state_d == S_G2) pending_q <= 1'b0;
    else if (bus.req2 && state_q != S_NIGHT)      pending_q <= 1'b1;
  end

`ifdef TRAFFIC_NIGHT_FLASH_EN
  logic blink_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       blink_q <= 1'b0;
    else if (state_d == S_NIGHT && state_q != S_NIGHT) blink_q <= 1'b0;
    else if (state_q == S_NIGHT && tick)               blink_q <= ~blink_q;
  end
`endif

  always_comb begin
    bus.led   = 6'b001001;
    bus.d     = 1'b1;
    bus.phase = 3'd0;
    case (state_q)
      S_G1:  begin bus.led = 6'b100001; bus.d = 1'b1; bus.phase = 3'd1; end
      S_Y1:  begin bus.led = 6'b010001; bus.d = 1'b1; bus.phase = 3'd2; end
      S_RR2: begin bus.led = 6'b001001; bus.d = 1'b0; bus.phase = 3'd3; end
      S_G2:  begin bus.led = 6'b001100; bus.d = 1'b0; bus.phase = 3'd4; end
      S_Y2:  begin bus.led = 6'b001010; bus.d = 1'b0; bus.phase = 3'd5; end
`ifdef TRAFFIC_NIGHT_FLASH_EN
      S_NIGHT: begin
        bus.led   = {1'b0, blink_q, 1'b0, 1'b0, blink_q, 1'b0};
        bus.d     = 1'b1;
        bus.phase = 3'd6;
      end
`endif
      default: begin bus.led = 6'b001001; bus.d = 1'b1; bus.phase = 3'd0; end
    endcase
  end

endmodule

// File: tb/tb_traffic_sequencer.sv
// tb/tb_traffic_sequencer.sv - directed scoreboard bench for traffic_sequencer
module tb_traffic_sequencer;

  localparam logic [2:0] P_RR1 = 3'd0, P_G1 = 3'd1, P_Y1 = 3'd2,
                         P_RR2 = 3'd3, P_G2 = 3'd4, P_Y2 = 3'd5, P_NT = 3'd6;
  localparam logic [5:0] L_RR = 6'b001001, L_G1 = 6'b100001, L_Y1 = 6'b010001,
                         L_G2 = 6'b001100, L_Y2 = 6'b001010;

  typedef struct {
    logic [2:0] ph;
    logic [5:0] led;
    logic       d;
    int         clks;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   elapsed = 0;
  logic [2:0] prev_phase = 3'd0;
  exp_t q[$];

  traffic_sequencer_if bus ();

  traffic_sequencer #(
    .CLK_DIV (4),
    .T_ALLRED(1),
    .T_GREEN1(3),
    .T_GREEN2(3),
    .T_YELLOW(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    elapsed++;
  endtask

  task automatic push(input logic [2:0] ph, input logic [5:0] led, input logic d, input int clks);
    q.push_back('{ph, led, d, clks});
  endtask

  // Pops each expected phase as the DUT moves into it; clks is time since the previous change.
  task automatic drain();
    exp_t e;
    int guard;
    while (q.size() > 0) begin
      e = q.pop_front();
      guard = 0;
      while (bus.phase === prev_phase && guard < 400) begin
        step();
        guard++;
      end
      check("phase", 32'(bus.phase), 32'(e.ph));
      check("led", 32'(bus.led), 32'(e.led));
      check("d", 32'(bus.d), 32'(e.d));
      check("clks", 32'(elapsed), 32'(e.clks));
      prev_phase = bus.phase;
      elapsed = 0;
    end
  endtask

  task automatic hold(input int n, input logic [5:0] exp_led);
    int bad;
    bad = 0;
    repeat (n) begin
      step();
      if (bus.led !== exp_led || bus.phase !== prev_phase) bad++;
    end
    check("hold", 32'(bad), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req2 = 1'b0;
    bus.night = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_led", 32'(bus.led), 32'(L_RR));
    check("rst_d", 32'(bus.d), 32'd1);
    check("rst_phase", 32'(bus.phase), 32'(P_RR1));
    rst_n = 1'b1;
    elapsed = 0;
    prev_phase = P_RR1;
    push(P_G1, L_G1, 1'b1, 4);
    drain();

    // Road-1 hold, then single-cycle request
    hold(40, L_G1);
    bus.req2 = 1'b1;
    step();
    bus.req2 = 1'b0;
    push(P_Y1, L_Y1, 1'b1, 44);
    push(P_RR2, L_RR, 1'b0, 8);
    push(P_G2, L_G2, 1'b0, 4);
    push(P_Y2, L_Y2, 1'b0, 12);
    push(P_RR1, L_RR, 1'b1, 8);
    push(P_G1, L_G1, 1'b1, 4);
    drain();

    // Continuous request: full 48-clk cycles
    bus.req2 = 1'b1;
    push(P_Y1, L_Y1, 1'b1, 12);
    push(P_RR2, L_RR, 1'b0, 8);
    push(P_G2, L_G2, 1'b0, 4);
    push(P_Y2, L_Y2, 1'b0, 12);
    push(P_RR1, L_RR, 1'b1, 8);
    push(P_G1, L_G1, 1'b1, 4);
    push(P_Y1, L_Y1, 1'b1, 12);
    push(P_RR2, L_RR, 1'b0, 8);
    push(P_G2, L_G2, 1'b0, 4);
    drain();

    // Asynchronous reset between edges during G2
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_phase", 32'(bus.phase), 32'(P_RR1));
    check("arst_led", 32'(bus.led), 32'(L_RR));
    check("arst_d", 32'(bus.d), 32'd1);
    bus.req2 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    elapsed = 0;
    prev_phase = P_RR1;
    push(P_G1, L_G1, 1'b1, 4);
    drain();
    hold(20, L_G1);

    // Request raised during G2 carries into the next G1
    bus.req2 = 1'b1;
    step();
    bus.req2 = 1'b0;
    push(P_Y1, L_Y1, 1'b1, 24);
    push(P_RR2, L_RR, 1'b0, 8);
    push(P_G2, L_G2, 1'b0, 4);
    drain();
    step();
    step();
    bus.req2 = 1'b1;
    step();
    bus.req2 = 1'b0;
    push(P_Y2, L_Y2, 1'b0, 12);
    push(P_RR1, L_RR, 1'b1, 8);
    push(P_G1, L_G1, 1'b1, 4);
    push(P_Y1, L_Y1, 1'b1, 12);
    push(P_RR2, L_RR, 1'b0, 8);
    push(P_G2, L_G2, 1'b0, 4);
    push(P_Y2, L_Y2, 1'b0, 12);
    push(P_RR1, L_RR, 1'b1, 8);
    push(P_G1, L_G1, 1'b1, 4);
    drain();
    hold(30, L_G1);

`ifdef TRAFFIC_NIGHT_FLASH_EN
    bus.night = 1'b1;
    push(P_NT, 6'b000000, 1'b1, 32);
    drain();
    repeat (4) step();
    check("blink_on", 32'(bus.led), 32'(6'b010010));
    repeat (4) step();
    check("blink_off", 32'(bus.led), 32'(6'b000000));
    bus.night = 1'b0;
    push(P_RR1, L_RR, 1'b1, 12);
    push(P_G1, L_G1, 1'b1, 4);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
